// File: rtl/comp_sub_seq.sv
// comp_sub_seq: digit-serial complement-add subtractor with a serial end-around-carry pass
module comp_sub_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            a_dig,
  input  logic [3:0]            y_dig,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  bcd_err
);
  localparam int IW = $clog2(DIGITS);
  typedef enum logic [1:0] {IDLE, ACCUM, EAC, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, carry_q, carry_d, neg_q, neg_d, err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] res_q, res_d;
  logic hs, last;
  logic [3:0] cur;
  logic [4:0] sum, dig;
  assign hs   = in_valid && state_q == ACCUM;
  assign last = idx_q == IW'(DIGITS - 1);
  assign cur  = res_q[4*idx_q +: 4];
  // shared digit adder: operand pair in ACCUM, stored digit plus carry in EAC; {carry, digit} out
  always_comb begin
    sum = state_q == EAC ? {1'b0, cur} + {4'b0, carry_q}
                         : {1'b0, a_dig} + {1'b0, y_dig} + {4'b0, carry_q};
    dig = !mode_q ? sum : sum > 5'd9 ? {1'b1, 4'(sum - 5'd10)} : {1'b0, sum[3:0]};
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state: an end carry detours through the fixed-length EAC pass
  always_comb begin
    state_d = (state_q == IDLE && start)         ? ACCUM :
              (state_q == ACCUM && hs && last)   ? (dig[4] ? EAC : DONE) :
              (state_q == EAC && last)           ? DONE :
              (state_q == DONE && out_ready)     ? IDLE : state_q;
  end
  // handshake outputs come straight from state, data outputs from registers
  always_comb begin
    in_ready  = state_q == ACCUM;
    out_valid = state_q == DONE;
    result    = res_q;
    neg       = neg_q;
    bcd_err   = err_q;
  end
  // datapath next values: clear on start, write one digit per accepted pair or EAC cycle
  always_comb begin
    mode_d  = mode_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    neg_d   = neg_q;
    err_d   = err_q;
    if (state_q == IDLE && start) begin
      mode_d  = mode;
      carry_d = 1'b0;
      idx_d   = '0;
      res_d   = '0;
      err_d   = 1'b0;
    end else if (hs || state_q == EAC) begin
      res_d[4*idx_q +: 4] = dig[3:0];
      carry_d = dig[4];
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (hs && mode_q && (a_dig > 4'd9 || y_dig > 4'd9)) err_d = 1'b1;
      if (last) neg_d = state_q == ACCUM ? !dig[4] : 1'b0;
    end
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_comp_sub_seq.sv
// tb_comp_sub_seq: directed vectors checked against an integer-arithmetic subtraction model
module tb_comp_sub_seq;
  localparam int D = 2;
  logic clk = 0, rst_n = 0, start = 0, mode = 0, in_valid = 0, out_ready = 0;
  logic [3:0] a_dig = 0, y_dig = 0;
  logic in_ready, out_valid, neg, bcd_err;
  logic [4*D-1:0] result;
  int checks = 0, failures = 0;
  logic armed = 0;
  logic [7:0] exp_res = 0;
  logic exp_neg = 0, exp_err = 0;

  comp_sub_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .a_dig(a_dig), .y_dig(y_dig), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .neg(neg), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {neg, result}: add the complement as integers, then fold an end carry back in
  function automatic logic [8:0] model(input bit m, input logic [7:0] a, input logic [7:0] y);
    int av, yv, base, s;
    logic [8:0] r;
    base = m ? 100 : 256;
    av = m ? a[7:4] * 10 + a[3:0] : int'(a);
    yv = m ? y[7:4] * 10 + y[3:0] : int'(y);
    s = av + yv;
    r[8] = s < base;
    if (s >= base) s = s - base + 1;
    r[7:0] = m ? {4'(s / 10), 4'(s % 10)} : 8'(s);
    return r;
  endfunction

  // every cycle with a result on the port, it must match the expectation for the current operation
  always @(negedge clk) if (rst_n) begin
    if (out_valid) begin
      chk("out_valid_expected", armed, 1);
      chk("result", result, exp_res);
      chk("neg", neg, exp_neg);
      chk("bcd_err", bcd_err, exp_err);
      chk("ready_valid_excl", in_ready, 0);
    end
  end

  task automatic send(input bit m, input logic [7:0] a, input logic [7:0] y, input bit gap);
    int n;
    @(posedge clk); #1 start = 1; mode = m;
    @(posedge clk); #1 start = 0; mode = ~m;
    for (int i = 0; i < D; i++) begin
      a_dig = a[4*i +: 4];
      y_dig = y[4*i +: 4];
      in_valid = 1;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("in_ready_wait", n < 20, 1);
      @(posedge clk); #1 in_valid = 0;
      if (gap && i < D - 1) begin
        start = 1;
        @(posedge clk); #1 start = 0;
      end
    end
  endtask

  task automatic op(input bit m, input logic [7:0] a, input logic [7:0] y, input bit gap,
                    input int stall, input bit ovr, input logic [7:0] ores, input bit oneg,
                    input bit oerr);
    logic [8:0] e;
    int n;
    e = model(m, a, y);
    exp_res = ovr ? ores : e[7:0];
    exp_neg = ovr ? oneg : e[8];
    exp_err = ovr ? oerr : 1'b0;
    armed = 1;
    send(m, a, y, gap);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, exp_neg ? 0 : D);
    for (int i = 0; i < stall; i++) begin
      start = 1;
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid, 1);
    end
    out_ready = 1;
    start = 1;
    @(posedge clk); #1 out_ready = 0; start = 0; armed = 0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("model_dec_52_17", model(1, 8'h52, 8'h82), {1'b0, 8'h35});
    chk("model_dec_17_52", model(1, 8'h17, 8'h47), {1'b1, 8'h64});
    chk("model_bin_35_12", model(0, 8'h35, 8'hED), {1'b0, 8'h23});
    chk("model_bin_35_35", model(0, 8'h35, 8'hCA), {1'b1, 8'hFF});
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_neg", neg, 0);
    chk("rst_bcd_err", bcd_err, 0);
    @(posedge clk); #1 rst_n = 1;
    op(1, 8'h52, 8'h82, 0, 0, 0, 0, 0, 0);
    op(1, 8'h17, 8'h47, 0, 0, 0, 0, 0, 0);
    op(0, 8'h35, 8'hED, 0, 0, 0, 0, 0, 0);
    op(0, 8'h35, 8'hCA, 0, 0, 0, 0, 0, 0);
    op(1, 8'h52, 8'h82, 1, 5, 0, 0, 0, 0);
    op(1, 8'h1C, 8'h00, 0, 0, 1, 8'h22, 1, 1);
    op(1, 8'h52, 8'h82, 0, 0, 0, 0, 0, 0);
    op(1, 8'h45, 8'h54, 0, 0, 0, 0, 0, 0);
    op(0, 8'h8F, 8'h80, 0, 2, 0, 0, 0, 0);
    op(1, 8'h59, 8'h41, 0, 0, 0, 0, 0, 0);
    op(0, 8'hFF, 8'hFF, 1, 0, 0, 0, 0, 0);
    op(1, 8'h99, 8'h99, 0, 0, 0, 0, 0, 0);
    send(1, 8'h52, 8'h82, 0);
    @(posedge clk); #1;
    chk("eac_busy", {in_ready, out_valid}, 0);
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_neg", neg, 0);
    chk("abort_bcd_err", bcd_err, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    chk("abort_stays_idle", {in_ready, out_valid}, 0);
    op(1, 8'h52, 8'h82, 0, 0, 0, 0, 0, 0);
    chk("final_result_literal", result, 8'h35);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
